// File: rtl/lib_pipe_pkg.sv
// rtl/lib_pipe_pkg.sv - shared sizing helpers for the pipelined valid/stall link blocks
package lib_pipe_pkg;

    // Entries that must stay free when stall is raised: both pipe directions,
    // the stall register and one cycle of sender reaction.
    function automatic int slack(input int stages);
        return 2 * stages + 2;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lib_pipe_term_if.sv
// rtl/lib_pipe_term_if.sv - link-side and consumer-side signals of the pipe terminator
interface lib_pipe_term_if #(
    parameter int WIDTH = 8
);
    logic             in_vld;
    logic [WIDTH-1:0] in_data;
    logic             stall;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;
    logic             ovf_err;

    modport master (
        output in_vld, in_data, out_rdy,
        input  stall, out_vld, out_data, ovf_err
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output stall, out_vld, out_data, ovf_err
    );
endinterface

// File: rtl/lib_pipe_term_ram.sv
// rtl/lib_pipe_term_ram.sv - DEPTH x WIDTH flop array, one write port, async read
module lib_pipe_term_ram
    import lib_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lib_pipe_term.sv
// rtl/lib_pipe_term.sv - receive-side skid buffer terminating a valid/stall pipe, FWFT output
// Optional sticky overflow flag and drop counter: define LIB_PIPE_TERM_OVF_EN.
module lib_pipe_term
    import lib_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1,
    parameter int DEPTH  = 16
) (
    input logic              clk,
    input logic              rst_n,
    lib_pipe_term_if.slave   bus
);

    localparam int SLACK = slack(STAGES);
    localparam int PW    = ptr_w(DEPTH);
    localparam int CW    = cnt_w(DEPTH);

    generate
        if (DEPTH < SLACK + 2) begin : g_depth_chk
            $error("lib_pipe_term: DEPTH must be at least 2*STAGES+4");
        end
    endgenerate

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             pop;
    logic             push_ok;
    logic             stall_q;
    logic [WIDTH-1:0] rdata;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full buffer can still take a beat when the head leaves in the same cycle.
    always_comb begin
        pop        = (count != '0) && bus.out_rdy;
        push_ok    = bus.in_vld && ((count < CW'(DEPTH)) || pop);
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= inc_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc_ptr(rd_ptr);
            end
            count   <= count_next;
            // free entries <= SLACK, judged on post-update occupancy
            stall_q <= (count_next >= CW'(DEPTH - SLACK));
        end
    end

    lib_pipe_term_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.stall    = stall_q;
    assign bus.out_vld  = (count != '0);
    assign bus.out_data = rdata;

`ifdef LIB_PIPE_TERM_OVF_EN
    logic        ovf_q;
    logic [15:0] drop_cnt;
    logic        drop;

    assign drop = bus.in_vld && !push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q    <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign bus.ovf_err = ovf_q;
`else
    assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_lib_pipe_term.sv
// tb/tb_lib_pipe_term.sv - scoreboard bench for lib_pipe_term (STAGES=2, DEPTH=16)
module tb_lib_pipe_term;

`ifdef LIB_PIPE_TERM_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] d;

    lib_pipe_term_if #(.WIDTH(8)) bus ();

    lib_pipe_term #(
        .WIDTH  (8),
        .STAGES (2),
        .DEPTH  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [7:0] v, input bit expect_accept);
        bus.in_vld  = 1'b1;
        bus.in_data = v;
        if (expect_accept) exp_q.push_back(v);
    endtask

    // Monitor: the handshake seen mid-cycle completes on the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got 0x%0h, expected no beat", bus.out_data);
            end else begin
                check("out_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = 8'h00;
        bus.out_rdy = 1'b0;
        repeat (3) step();
        check("rst_stall",    {31'd0, bus.stall},   32'd0);
        check("rst_out_vld",  {31'd0, bus.out_vld}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_ovf_err",  {31'd0, bus.ovf_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming with consumer always ready
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            push_beat(8'(i), 1'b1);
            step();
            check("stream_vld",   {31'd0, bus.out_vld}, 32'd1);
            check("stream_stall", {31'd0, bus.stall},   32'd0);
        end
        bus.in_vld = 1'b0;
        step();
        check("stream_empty", {31'd0, bus.out_vld}, 32'd0);

        // Stall threshold: 16 - 10 = 6 free entries
        bus.out_rdy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            push_beat(8'h80 + 8'(k - 1), 1'b1);
            step();
            check("thr_stall", {31'd0, bus.stall}, (k >= 10) ? 32'd1 : 32'd0);
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        step();
        check("thr_release", {31'd0, bus.stall}, 32'd0);
        repeat (9) step();
        check("thr_drained", {31'd0, bus.out_vld}, 32'd0);

        // Wrap-around: fill 12 / drain 12, five times
        d = 8'h10;
        for (int r = 0; r < 5; r++) begin
            bus.out_rdy = 1'b0;
            for (int k = 0; k < 12; k++) begin
                push_beat(d, 1'b1);
                d = d + 8'd1;
                step();
            end
            check("wrap_stall", {31'd0, bus.stall}, 32'd1);
            bus.in_vld  = 1'b0;
            bus.out_rdy = 1'b1;
            repeat (12) step();
            check("wrap_empty", {31'd0, bus.out_vld}, 32'd0);
        end

        // Full buffer: simultaneous push+pop accepted, then a drop
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 16; k++) begin
            push_beat(8'hA0 + 8'(k), 1'b1);
            step();
        end
        check("full_ovf0", {31'd0, bus.ovf_err}, 32'd0);
        push_beat(8'hC0, 1'b1);
        bus.out_rdy = 1'b1;
        step();
        check("full_pp_ovf", {31'd0, bus.ovf_err}, 32'd0);
        check("full_pp_stall", {31'd0, bus.stall}, 32'd1);
        bus.out_rdy = 1'b0;
        push_beat(8'hEE, 1'b0);
        step();
        check("full_drop_ovf", {31'd0, bus.ovf_err}, {31'd0, EXP_OVF});
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (16) step();
        check("full_drained", {31'd0, bus.out_vld}, 32'd0);

        // Asynchronous reset with 7 beats buffered
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            push_beat(8'h50 + 8'(k), 1'b1);
            step();
        end
        bus.in_vld = 1'b0;
        check("pre_rst_vld", {31'd0, bus.out_vld}, 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_vld",  {31'd0, bus.out_vld},  32'd0);
        check("arst_stall",    {31'd0, bus.stall},    32'd0);
        check("arst_ovf",      {31'd0, bus.ovf_err},  32'd0);
        check("arst_out_data", {24'd0, bus.out_data}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        push_beat(8'h77, 1'b1);
        bus.out_rdy = 1'b1;
        step();
        check("post_rst_vld", {31'd0, bus.out_vld}, 32'd1);
        bus.in_vld = 1'b0;
        step();
        check("post_rst_empty", {31'd0, bus.out_vld}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_pipe_term.md
# lib_pipe_term

Receive-side terminator for a pipelined valid/stall link. Data arrives through STAGES forward flop stages. The stall indication travels back through STAGES reverse flop stages. This block buffers every beat still in flight after it raises stall, so nothing is lost. It presents a first-word-fall-through valid/ready interface to the downstream consumer.

## Interface
- WIDTH, 8: data width in bits.
- STAGES, 1: flop stages in each direction of the link (forward data, reverse stall).
- DEPTH, 16: buffer entries; must be ≥ SLACK+2. Elaboration-time error otherwise.
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_vld  input  1  beat present on in_data (from far end of forward pipe).
- in_data  input  WIDTH  beat payload.
- stall  output  1  registered; drives the reverse pipe back to the sender.
- out_vld  output  1  buffer non-empty.
- out_data  output  WIDTH  head-of-buffer payload, valid when out_vld.
- out_rdy  input  1  consumer accepts head when out_vld && out_rdy.
- ovf_err  output  1  sticky overflow flag (see Configuration).

## Operation
- SLACK = 2*STAGES + 2. This covers forward pipe, reverse pipe, the stall register, and one cycle of sender reaction.
- Storage: DEPTH-entry flop array with wr_ptr, rd_ptr (width $clog2(DEPTH), wrap DEPTH-1→0) and count (width $clog2(DEPTH+1)).
- Push: in_vld writes mem[wr_ptr], wr_ptr++. Accepted iff count < DEPTH, or count == DEPTH and a pop occurs in the same cycle.
- Pop: out_vld && out_rdy → rd_ptr++.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push while full with no pop: beat dropped, pointers and count unchanged, overflow event.
- stall next-state = (DEPTH − count_next) ≤ SLACK. It is computed from post-update occupancy. There is no hysteresis.
- out_vld = (count != 0). out_data = mem[rd_ptr]; it is don't-care when out_vld = 0 but deterministic (flops reset).
- The sender contract is the only flow-control guarantee. A sender that ignores stall can overflow the buffer.
- Reset values: stall 0, out_vld 0, out_data 0, ovf_err 0. Pointers, count and array are all 0.
- Reset mid-operation: all buffered beats are discarded immediately (asynchronous). The first post-reset push lands at index 0.

## Timing
- Push-to-visible latency: in_vld at edge N → out_vld = 1 and out_data valid after edge N (cycle N+1).
- Empty buffer, out_rdy held high: one beat per cycle throughput, one cycle latency. There is no combinational in→out path.
- stall reflects occupancy after edge N at cycle N+1. It reaches the sender STAGES cycles later.
- Pop frees its entry for a same-cycle push only when the buffer is full. Otherwise normal push rules apply.

## Configuration
- LIB_PIPE_TERM_OVF_EN defined:
  - ovf_err sets on the first dropped beat and holds until rst_n.
  - A 16-bit saturating drop counter is kept internally for debug probing.
- LIB_PIPE_TERM_OVF_EN undefined:
  - ovf_err is tied to 0 and there is no counter logic.
  - Overflow behaviour (beat dropped, state unchanged) is identical.

## Structure
- Shared package lib_pipe_pkg holds:
  - a function slack(STAGES) returning 2*STAGES+2;
  - a localparam macro-free helper for pointer/count widths.
- One sub-module, lib_pipe_term_ram: DEPTH×WIDTH flop array with write port (we, waddr, wdata) and async read (raddr → rdata). It is reset to 0. The top level holds pointers, count, stall and error logic.

## Test plan
- Reset check (STAGES=2, DEPTH=16, SLACK=6): hold rst_n low → stall=0, out_vld=0, out_data=0, ovf_err=0.
- Streaming: in_vld every cycle with data 0x00..0x3F, out_rdy=1 → out_data 0x00..0x3F, each one cycle after input; count ≤1; stall never asserts.
- Stall threshold: out_rdy=0, push 10 beats → stall rises the cycle after the 10th push (free=6). Pop one with no push → stall falls next cycle.
- Wrap-around: fill to 12, drain 12, repeat 5 times with incrementing data → order preserved across pointer wrap; no loss.
- Full with simultaneous push+pop: count=16, in_vld=1, out_rdy=1 → beat accepted, count stays 16, ovf_err stays 0. Then push with out_rdy=0 → beat dropped. ovf_err=1 when the macro is defined, 0 when undefined.
- Async reset mid-stream: assert rst_n low between edges with count=7 → out_vld and stall drop immediately. First beat after release is output as the first beat.
